// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_if
//  Brief    : Bundle of IF/ID inputs, write-back bypass and EX-stage outputs
//  Revision : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [31:0]       instr;
    logic [31:0]       pc_plus4;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;

    logic              ex_valid;
    logic [31:0]       ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_RegDst;
    logic              ex_ALUSrc;
    logic              ex_MemtoReg;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_Branch;
    logic [1:0]        ex_ALUOp;
    logic              illegal_op;

    // Upstream side (IF/ID, register file, hazard unit, write-back)
    modport master (
        output stall, flush, in_valid, instr, pc_plus4, ReadData1, ReadData2,
               wb_reg_write, wb_write_reg, wb_write_data,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_RegDst, ex_ALUSrc, ex_MemtoReg,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               illegal_op
    );

    // Pipeline register side
    modport slave (
        input  stall, flush, in_valid, instr, pc_plus4, ReadData1, ReadData2,
               wb_reg_write, wb_write_reg, wb_write_data,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_RegDst, ex_ALUSrc, ex_MemtoReg,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : MIPS ID/EX stage - main decode, WB bypass, sign-extend, EX regs
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire     clk,
    input  wire     rst,
    id_ex_if.slave  bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;

    localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

    // Control word order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0]
    localparam int c_CTRL_W = 9;

    logic [5:0]          w_opcode;
    logic [REG_AW-1:0]   w_rs;
    logic [REG_AW-1:0]   w_rt;
    logic [REG_AW-1:0]   w_rd;
    logic                w_legal;
    logic [c_CTRL_W-1:0] w_ctrl;
    logic                w_byp_a;
    logic                w_byp_b;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;
    logic [DATA_W-1:0]   w_imm;

    logic                r_valid;
    logic [31:0]         r_pc_plus4;
    logic [DATA_W-1:0]   r_rs_data;
    logic [DATA_W-1:0]   r_rt_data;
    logic [DATA_W-1:0]   r_imm;
    logic [REG_AW-1:0]   r_rs;
    logic [REG_AW-1:0]   r_rt;
    logic [REG_AW-1:0]   r_rd;
    logic [c_CTRL_W-1:0] r_ctrl;
    logic                r_illegal_op;

    assign w_opcode = bus.instr[31:26];
    assign w_rs     = bus.instr[25:21];
    assign w_rt     = bus.instr[20:16];
    assign w_rd     = bus.instr[15:11];
    assign w_imm    = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};

    always_comb begin
        w_legal = 1'b1;
        w_ctrl  = '0;
        case (w_opcode)
            c_OP_RTYPE: w_ctrl = 9'b1_0_0_1_0_0_0_10;
            c_OP_LW:    w_ctrl = 9'b0_1_1_1_1_0_0_00;
            c_OP_SW:    w_ctrl = 9'b0_1_0_0_0_1_0_00;
            c_OP_BEQ:   w_ctrl = 9'b0_0_0_0_0_0_1_01;
            c_OP_ADDI:  w_ctrl = 9'b0_1_0_1_0_0_0_00;
            default:    w_legal = 1'b0;
        endcase
    end

    // $0 is never forwarded so it keeps reading as zero from the file
    assign w_byp_a = bus.wb_reg_write && (bus.wb_write_reg != c_REG_ZERO) &&
                     (bus.wb_write_reg == w_rs);
    assign w_byp_b = bus.wb_reg_write && (bus.wb_write_reg != c_REG_ZERO) &&
                     (bus.wb_write_reg == w_rt);
    assign w_op_a  = w_byp_a ? bus.wb_write_data : bus.ReadData1;
    assign w_op_b  = w_byp_b ? bus.wb_write_data : bus.ReadData2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc_plus4   <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
            r_illegal_op <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: kill valid and controls, data fields are don't-care
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_pc_plus4 <= bus.pc_plus4;
            r_rs_data  <= w_op_a;
            r_rt_data  <= w_op_b;
            r_imm      <= w_imm;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_rd       <= w_rd;
        end else if (!bus.stall) begin
            r_valid    <= bus.in_valid && w_legal;
            r_ctrl     <= bus.in_valid ? w_ctrl : '0;
            r_pc_plus4 <= bus.pc_plus4;
            r_rs_data  <= w_op_a;
            r_rt_data  <= w_op_b;
            r_imm      <= w_imm;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_rd       <= w_rd;
            if (bus.in_valid && !w_legal) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    assign bus.ex_valid    = r_valid;
    assign bus.ex_pc_plus4 = r_pc_plus4;
    assign bus.ex_rs_data  = r_rs_data;
    assign bus.ex_rt_data  = r_rt_data;
    assign bus.ex_imm      = r_imm;
    assign bus.ex_rs       = r_rs;
    assign bus.ex_rt       = r_rt;
    assign bus.ex_rd       = r_rd;
    assign bus.ex_RegDst   = r_ctrl[8];
    assign bus.ex_ALUSrc   = r_ctrl[7];
    assign bus.ex_MemtoReg = r_ctrl[6];
    assign bus.ex_RegWrite = r_ctrl[5];
    assign bus.ex_MemRead  = r_ctrl[4];
    assign bus.ex_MemWrite = r_ctrl[3];
    assign bus.ex_Branch   = r_ctrl[2];
    assign bus.ex_ALUOp    = r_ctrl[1:0];
    assign bus.illegal_op  = r_illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Directed self-checking bench for id_ex_stage
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    localparam logic [8:0] c_CTRL_R    = 9'b100100010;
    localparam logic [8:0] c_CTRL_LW   = 9'b011110000;
    localparam logic [8:0] c_CTRL_SW   = 9'b010001000;
    localparam logic [8:0] c_CTRL_BEQ  = 9'b000000101;
    localparam logic [8:0] c_CTRL_NONE = 9'b000000000;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    id_ex_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]   w_ctrl;
    logic [153:0] w_all;
    assign w_ctrl = {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
                     bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_ALUOp};
    assign w_all  = {bus.ex_valid, bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data,
                     bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd, w_ctrl, bus.illegal_op};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2);
        bus.in_valid  = 1'b1;
        bus.instr     = instr;
        bus.pc_plus4  = pc;
        bus.ReadData1 = rd1;
        bus.ReadData2 = rd2;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.wb_reg_write = 1'b0;
        bus.wb_write_reg = '0;
        bus.wb_write_data = '0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, $urandom);
            bus.in_valid      = 1'($urandom);
            bus.wb_reg_write  = 1'($urandom);
            bus.wb_write_reg  = 5'($urandom);
            bus.wb_write_data = $urandom;
            tick();
            total_cnt++;
            if (w_all !== '0) $display("FAIL reset_hold: got %h expected 0", w_all);
            else pass_cnt++;
        end
        bus.wb_reg_write = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        rst = 1'b0;
        drive(32'h012A4020, 32'h0000_0104, 32'd9, 32'd10);
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_rt, bus.ex_rd} !==
            {1'b1, c_CTRL_R, 5'd9, 5'd10, 5'd8})
            $display("FAIL first_capture_ctrl: got %b %b %0d %0d %0d expected 1 %b 9 10 8",
                     bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_rt, bus.ex_rd, c_CTRL_R);
        else pass_cnt++;
        total_cnt++;
        if ({bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc_plus4} !==
            {32'd9, 32'd10, 32'h0000_4020, 32'h0000_0104})
            $display("FAIL first_capture_data: got %h %h %h %h expected 9 a 4020 104",
                     bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc_plus4);
        else pass_cnt++;
    endtask

    task automatic test_lw();
        drive(32'h8D28FFFC, 32'h0000_0108, 32'h100, 32'h200);
        tick();
        total_cnt++;
        if (bus.ex_imm !== 32'hFFFF_FFFC)
            $display("FAIL lw_imm: got %h expected fffffffc", bus.ex_imm);
        else pass_cnt++;
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_rt} !== {1'b1, c_CTRL_LW, 5'd9, 5'd8})
            $display("FAIL lw_ctrl: got %b %b %0d %0d expected 1 %b 9 8",
                     bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_rt, c_CTRL_LW);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        bus.wb_reg_write  = 1'b1;
        bus.wb_write_reg  = 5'd9;
        bus.wb_write_data = 32'hDEAD_BEEF;
        drive(32'h8D28FFFC, 32'h0000_010C, 32'd9, 32'd8);
        tick();
        total_cnt++;
        if ({bus.ex_rs_data, bus.ex_rt_data} !== {32'hDEAD_BEEF, 32'd8})
            $display("FAIL bypass_a: got %h %h expected deadbeef 00000008",
                     bus.ex_rs_data, bus.ex_rt_data);
        else pass_cnt++;
        bus.wb_write_reg = 5'd8;
        tick();
        total_cnt++;
        if ({bus.ex_rs_data, bus.ex_rt_data} !== {32'd9, 32'hDEAD_BEEF})
            $display("FAIL bypass_b: got %h %h expected 00000009 deadbeef",
                     bus.ex_rs_data, bus.ex_rt_data);
        else pass_cnt++;
        bus.wb_reg_write = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_rs_data, bus.ex_rt_data} !== {32'd9, 32'd8})
            $display("FAIL bypass_disabled: got %h %h expected 00000009 00000008",
                     bus.ex_rs_data, bus.ex_rt_data);
        else pass_cnt++;
        bus.wb_reg_write = 1'b1;
        bus.wb_write_reg = 5'd0;
        drive(32'h0000_4020, 32'h0000_0110, 32'd0, 32'd0);
        tick();
        total_cnt++;
        if ({bus.ex_rs_data, bus.ex_rt_data} !== 64'd0)
            $display("FAIL bypass_r0: got %h %h expected 0 0", bus.ex_rs_data, bus.ex_rt_data);
        else pass_cnt++;
        bus.wb_reg_write = 1'b0;
    endtask

    task automatic test_stall();
        logic [153:0] exp;
        exp = {1'b1, 32'h0000_0200, 32'd9, 32'd10, 32'h0000_4020,
               5'd9, 5'd10, 5'd8, c_CTRL_R, 1'b0};
        drive(32'h012A4020, 32'h0000_0200, 32'd9, 32'd10);
        tick();
        bus.stall = 1'b1;
        bus.wb_reg_write  = 1'b1;
        bus.wb_write_reg  = 5'd8;
        bus.wb_write_data = 32'h1234_5678;
        drive(32'hAD0A0004, 32'h0000_0204, 32'h55, 32'h66);
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (w_all !== exp) $display("FAIL stall_hold%0d: got %h expected %h", i, w_all, exp);
            else pass_cnt++;
        end
        bus.stall = 1'b0;
        bus.wb_reg_write = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_imm, bus.ex_rt_data} !==
            {1'b1, c_CTRL_SW, 5'd8, 32'd4, 32'h66})
            $display("FAIL stall_release: got %b %b %0d %h %h expected 1 %b 8 4 66",
                     bus.ex_valid, w_ctrl, bus.ex_rs, bus.ex_imm, bus.ex_rt_data, c_CTRL_SW);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(32'h112A0003, 32'h0000_0300, 32'd1, 32'd2);
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl} !== {1'b0, c_CTRL_NONE})
            $display("FAIL flush_over_stall: got %b %b expected 0 %b", bus.ex_valid, w_ctrl, c_CTRL_NONE);
        else pass_cnt++;
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.ex_imm} !== {1'b1, c_CTRL_BEQ, 32'd3})
            $display("FAIL beq_capture: got %b %b %h expected 1 %b 3",
                     bus.ex_valid, w_ctrl, bus.ex_imm, c_CTRL_BEQ);
        else pass_cnt++;
        bus.flush = 1'b1;
        drive(32'h8D28FFFC, 32'h0000_0304, 32'd1, 32'd2);
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl} !== {1'b0, c_CTRL_NONE})
            $display("FAIL flush_only: got %b %b expected 0 %b", bus.ex_valid, w_ctrl, c_CTRL_NONE);
        else pass_cnt++;
        bus.flush = 1'b0;
        drive(32'h012A4020, 32'h0000_0308, 32'd1, 32'd2);
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl} !== {1'b0, c_CTRL_NONE})
            $display("FAIL invalid_slot: got %b %b expected 0 %b", bus.ex_valid, w_ctrl, c_CTRL_NONE);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        drive(32'hFC00_0000, 32'h0000_0400, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_valid, bus.illegal_op} !== 2'b00)
            $display("FAIL illegal_not_valid: got %b %b expected 0 0", bus.ex_valid, bus.illegal_op);
        else pass_cnt++;
        bus.in_valid = 1'b1;
        bus.stall    = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        tick();
        total_cnt++;
        if (bus.illegal_op !== 1'b0)
            $display("FAIL illegal_blocked: got %b expected 0", bus.illegal_op);
        else pass_cnt++;
        bus.flush = 1'b0;
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.illegal_op} !== {1'b0, c_CTRL_NONE, 1'b1})
            $display("FAIL illegal_set: got %b %b %b expected 0 %b 1",
                     bus.ex_valid, w_ctrl, bus.illegal_op, c_CTRL_NONE);
        else pass_cnt++;
        drive(32'h012A4020, 32'h0000_0404, 32'd9, 32'd10);
        tick();
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.illegal_op} !== {1'b1, c_CTRL_R, 1'b1})
            $display("FAIL illegal_sticky: got %b %b %b expected 1 %b 1",
                     bus.ex_valid, w_ctrl, bus.illegal_op, c_CTRL_R);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (w_all !== '0) $display("FAIL async_reset: got %h expected 0", w_all);
        else pass_cnt++;
        tick();
        #2;
        rst = 1'b0;
        drive(32'h8D28FFFC, 32'h0000_0500, 32'd7, 32'd8);
        tick();
        total_cnt++;
        if ({bus.ex_valid, w_ctrl, bus.illegal_op, bus.ex_rs_data} !==
            {1'b1, c_CTRL_LW, 1'b0, 32'd7})
            $display("FAIL post_reset_capture: got %b %b %b %h expected 1 %b 0 7",
                     bus.ex_valid, w_ctrl, bus.illegal_op, bus.ex_rs_data, c_CTRL_LW);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_lw();
        test_bypass();
        test_stall();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
